// File: rtl/io_supply_sequencer_pkg.sv
// io_seq_pkg: shared types and constants for the IO supply sequencer.
//   io_seq_state_e : FSM state encoding (also exported on state_o)
//   io_seq_out_t   : pad control bundle {iso, ret, oe_en, ready}
//   SAFE_OUT       : pad controls for the safe (unpowered) ring
//   DROP_CNT_MAX   : saturation value of the supply-drop counter
package io_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_ISO_REL  = 3'd2,
    ST_RET_REL  = 3'd3,
    ST_READY    = 3'd4
  } io_seq_state_e;

  typedef struct packed {
    logic iso;
    logic ret;
    logic oe_en;
    logic ready;
  } io_seq_out_t;

  localparam io_seq_out_t SAFE_OUT     = '{iso: 1'b1, ret: 1'b1, oe_en: 1'b0, ready: 1'b0};
  localparam logic [7:0]  DROP_CNT_MAX = 8'hFF;

  // Moore decode of pad controls; unknown encodings map to the safe state.
  function automatic io_seq_out_t decode_out(input io_seq_state_e st);
    io_seq_out_t o;
    o = SAFE_OUT;
    case (st)
      ST_ISO_REL: o = '{iso: 1'b0, ret: 1'b1, oe_en: 1'b0, ready: 1'b0};
      ST_RET_REL: o = '{iso: 1'b0, ret: 1'b0, oe_en: 1'b0, ready: 1'b0};
      ST_READY:   o = '{iso: 1'b0, ret: 1'b0, oe_en: 1'b1, ready: 1'b1};
      default:    o = SAFE_OUT;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/io_supply_sequencer_if.sv
// io_supply_sequencer_if: bundles the supply-detect input, software controls,
// configuration and pad-control outputs of the sequencer.
//   slave  : sequencer side (consumes vsup/force/cfg, drives pad controls)
//   master : ring-controller side (drives vsup/force/cfg, observes outputs)
interface io_supply_sequencer_if #(
  parameter int unsigned DEBOUNCE_W = 8,
  parameter int unsigned STEP_W     = 8
);
  logic                  vsup_ok_ai;
  logic                  force_off_i;
  logic [DEBOUNCE_W-1:0] cfg_debounce_i;
  logic [STEP_W-1:0]     cfg_step_i;
  logic                  pad_iso_o;
  logic                  pad_ret_o;
  logic                  pad_oe_en_o;
  logic                  io_ready_o;
  logic [2:0]            state_o;
  logic [7:0]            drop_cnt_o;

  modport master (
    output vsup_ok_ai, force_off_i, cfg_debounce_i, cfg_step_i,
    input  pad_iso_o, pad_ret_o, pad_oe_en_o, io_ready_o, state_o, drop_cnt_o
  );

  modport slave (
    input  vsup_ok_ai, force_off_i, cfg_debounce_i, cfg_step_i,
    output pad_iso_o, pad_ret_o, pad_oe_en_o, io_ready_o, state_o, drop_cnt_o
  );
endinterface

// File: rtl/io_supply_sequencer_sync.sv
// io_sync_ff: STAGES-deep flop chain bringing an asynchronous level into clk_i.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, chain clears to 0
//   d_ai   : asynchronous input level
//   q_o    : synchronised level, STAGES edges after d_ai settles
module io_sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_ai,
  output logic q_o
);
  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[STAGES-2:0], d_ai};
  end

  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/io_supply_sequencer.sv
// io_supply_sequencer: power-up/power-down sequencer for the IO ring.
// Debounces the synchronised supply-good level, then releases isolation,
// retention and output enables in order; any loss returns the ring to the
// safe state on the next edge and supply drops are counted (saturating).
//   clk_i, rst_ni : block clock, asynchronous active-low reset
//   io (slave)    : vsup_ok_ai, force_off_i, cfg_debounce_i, cfg_step_i in;
//                   pad_iso_o, pad_ret_o, pad_oe_en_o, io_ready_o,
//                   state_o, drop_cnt_o out
module io_supply_sequencer
  import io_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE_W  = 8,
  parameter int unsigned STEP_W      = 8
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  io_supply_sequencer_if.slave io
);
  localparam int unsigned CNT_W = (DEBOUNCE_W > STEP_W) ? DEBOUNCE_W : STEP_W;

  io_seq_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       drop_q, drop_d;
  io_seq_out_t      out_q;

  logic              ok_s;
  logic              loss;
  logic [STEP_W-1:0] step_len;
  logic              deb_done;
  logic              step_done;

  io_sync_ff #(.STAGES(SYNC_STAGES)) u_vsup_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_ai   (io.vsup_ok_ai),
    .q_o    (ok_s)
  );

  always_comb begin
    loss      = !ok_s || io.force_off_i;
    step_len  = (io.cfg_step_i == '0) ? STEP_W'(1) : io.cfg_step_i;
    deb_done  = (cnt_q == CNT_W'(io.cfg_debounce_i));
    // counter starts at 0 on stage entry, so the last cycle of a stage sees len-1
    step_done = (cnt_q == CNT_W'(step_len - STEP_W'(1)));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    case (state_q)
      ST_OFF: begin
        cnt_d = '0;
        if (!loss) state_d = ST_DEBOUNCE;
      end
      ST_DEBOUNCE: begin
        if (loss) begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end else if (deb_done) begin
          state_d = ST_ISO_REL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ISO_REL, ST_RET_REL: begin
        if (loss) begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end else if (step_done) begin
          state_d = (state_q == ST_ISO_REL) ? ST_RET_REL : ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_READY: begin
        if (loss) state_d = ST_OFF;
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end
    endcase
    // only a genuine supply loss after debounce counts as a drop
    if (loss && !ok_s &&
        (state_q == ST_ISO_REL || state_q == ST_RET_REL || state_q == ST_READY) &&
        drop_q != DROP_CNT_MAX)
      drop_d = drop_q + 8'd1;
  end

  // Outputs are registered from the next state so they switch with state_q.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      drop_q  <= '0;
      out_q   <= SAFE_OUT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      out_q   <= decode_out(state_d);
    end
  end

  assign io.pad_iso_o   = out_q.iso;
  assign io.pad_ret_o   = out_q.ret;
  assign io.pad_oe_en_o = out_q.oe_en;
  assign io.io_ready_o  = out_q.ready;
  assign io.state_o     = state_q;
  assign io.drop_cnt_o  = drop_q;
endmodule

// File: tb/tb_io_supply_sequencer.sv
// Self-checking bench for io_supply_sequencer: expected output vectors are
// queued with the cycle they are due and compared on the falling edge.
module tb_io_supply_sequencer;
  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  io_supply_sequencer_if #(.DEBOUNCE_W(8), .STEP_W(8)) io ();

  io_supply_sequencer #(.SYNC_STAGES(2), .DEBOUNCE_W(8), .STEP_W(8)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .io     (io)
  );

  typedef struct {
    int unsigned due;
    string       tag;
    logic [14:0] exp;
  } sb_t;

  sb_t         sb[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  always @(posedge clk_i) cyc++;

  // {iso, ret, oe_en, ready, state[2:0], drop[7:0]}
  function automatic logic [14:0] mk(input logic [2:0] st, input logic [7:0] drop);
    logic [3:0] pads;
    case (st)
      3'd2:    pads = 4'b0100;
      3'd3:    pads = 4'b0000;
      3'd4:    pads = 4'b0011;
      default: pads = 4'b1100;
    endcase
    return {pads, st, drop};
  endfunction

  function automatic logic [14:0] observed();
    return {io.pad_iso_o, io.pad_ret_o, io.pad_oe_en_o, io.io_ready_o,
            io.state_o, io.drop_cnt_o};
  endfunction

  task automatic expect_at(input int unsigned n, input string tag,
                           input logic [2:0] st, input logic [7:0] drop);
    sb_t e;
    e.due = cyc + n;
    e.tag = tag;
    e.exp = mk(st, drop);
    sb.push_back(e);
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  always @(negedge clk_i) begin
    sb_t         e;
    logic [14:0] obs;
    while (sb.size() != 0 && sb[0].due <= cyc) begin
      e   = sb.pop_front();
      obs = observed();
      n_checks++;
      assert (obs === e.exp && e.due == cyc) else begin
        n_fail++;
        $error("FAIL %s: observed %h required %h (cycle %0d, due %0d)",
               e.tag, obs, e.exp, cyc, e.due);
      end
    end
  end

  initial begin
    logic [7:0]  exp_drop;
    logic [14:0] obs;
    rst_ni            = 1'b0;
    io.vsup_ok_ai     = 1'b0;
    io.force_off_i    = 1'b0;
    io.cfg_debounce_i = 8'd4;
    io.cfg_step_i     = 8'd3;

    // reset state
    tick(3);
    expect_at(0, "reset_state", 3'd0, 8'd0);
    tick(1);
    rst_ni = 1'b1;
    tick(2);

    // glitch: supply good for only 3 cycles, D=4
    io.vsup_ok_ai = 1'b1;
    expect_at(3, "glitch_deb", 3'd1, 8'd0);
    tick(3);
    io.vsup_ok_ai = 1'b0;
    expect_at(2, "glitch_deb_hold", 3'd1, 8'd0);
    expect_at(3, "glitch_off", 3'd0, 8'd0);
    expect_at(6, "glitch_stay_off", 3'd0, 8'd0);
    tick(8);

    // full power-up S=2 D=4 T=3
    io.vsup_ok_ai = 1'b1;
    expect_at(2,  "up_sync_off", 3'd0, 8'd0);
    expect_at(3,  "up_deb", 3'd1, 8'd0);
    expect_at(7,  "up_deb_last", 3'd1, 8'd0);
    expect_at(8,  "up_iso_rel", 3'd2, 8'd0);
    expect_at(10, "up_iso_last", 3'd2, 8'd0);
    expect_at(11, "up_ret_rel", 3'd3, 8'd0);
    expect_at(13, "up_ret_last", 3'd3, 8'd0);
    expect_at(14, "up_ready", 3'd4, 8'd0);
    tick(16);

    // supply drop from READY, then re-rise
    io.vsup_ok_ai = 1'b0;
    expect_at(2, "drop_still_ready", 3'd4, 8'd0);
    expect_at(3, "drop_off", 3'd0, 8'd1);
    tick(3);
    io.vsup_ok_ai = 1'b1;
    expect_at(8,  "rerise_iso", 3'd2, 8'd1);
    expect_at(14, "rerise_ready", 3'd4, 8'd1);
    tick(14);

    // force_off pulse from READY, then from RET_REL
    io.force_off_i = 1'b1;
    expect_at(1, "force_ready_off", 3'd0, 8'd1);
    tick(1);
    io.force_off_i = 1'b0;
    expect_at(1, "force_restart_deb", 3'd1, 8'd1);
    expect_at(6, "force_restart_iso", 3'd2, 8'd1);
    expect_at(9, "force_restart_ret", 3'd3, 8'd1);
    tick(10);
    io.force_off_i = 1'b1;
    expect_at(1, "force_ret_off", 3'd0, 8'd1);
    tick(1);
    io.force_off_i = 1'b0;
    expect_at(1,  "force_ret_deb", 3'd1, 8'd1);
    expect_at(12, "force_ret_ready", 3'd4, 8'd1);
    tick(12);

    // D=0, T=0: each stage one cycle
    io.vsup_ok_ai = 1'b0;
    expect_at(3, "drop2_off", 3'd0, 8'd2);
    tick(3);
    io.cfg_debounce_i = 8'd0;
    io.cfg_step_i     = 8'd0;
    io.vsup_ok_ai     = 1'b1;
    expect_at(3, "fast_deb", 3'd1, 8'd2);
    expect_at(4, "fast_iso", 3'd2, 8'd2);
    expect_at(5, "fast_ret", 3'd3, 8'd2);
    expect_at(6, "fast_ready", 3'd4, 8'd2);
    tick(6);

    // repeated drops: counter saturates
    for (int i = 0; i < 300; i++) begin
      exp_drop = (i + 3 > 255) ? 8'hFF : 8'(i + 3);
      io.vsup_ok_ai = 1'b0;
      expect_at(3, "sat_off", 3'd0, exp_drop);
      tick(3);
      io.vsup_ok_ai = 1'b1;
      expect_at(6, "sat_ready", 3'd4, exp_drop);
      tick(6);
    end

    // asynchronous reset mid-sequence
    io.vsup_ok_ai = 1'b0;
    expect_at(3, "pre_rst_off", 3'd0, 8'hFF);
    tick(3);
    io.vsup_ok_ai = 1'b1;
    expect_at(4, "pre_rst_iso", 3'd2, 8'hFF);
    tick(4);
    @(negedge clk_i);
    #1;
    rst_ni = 1'b0;
    #1;
    obs = observed();
    n_checks++;
    assert (obs === mk(3'd0, 8'd0)) else begin
      n_fail++;
      $error("FAIL async_reset: observed %h required %h", obs, mk(3'd0, 8'd0));
    end
    tick(2);
    rst_ni = 1'b1;

    for (int k = 0; k < 20 && sb.size() != 0; k++) tick(1);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL drain: observed %0d pending required 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule

// File: doc/io_supply_sequencer.md
# io_supply_sequencer

Digital power-up/power-down sequencer for the GF22FDX IO ring, sitting directly downstream of the IO supply pad and its supply-detect cell. It synchronises and debounces the asynchronous "VDDIO good" indication, then releases pad isolation, retention and output enables in a fixed, programmable order. On supply loss or a software force-off it returns the pads to the safe state within one cycle of detection, and it counts supply drops.

## Interface
Parameters:
- SYNC_STAGES, 2, flops in the vsup_ok_ai synchroniser (≥2)
- DEBOUNCE_W, 8, width of the debounce counter and cfg_debounce_i
- STEP_W, 8, width of the step counter and cfg_step_i

Ports:
- clk_i  in  1  single block clock
- rst_ni  in  1  asynchronous, active-low reset
- vsup_ok_ai  in  1  asynchronous supply-good from the detector, 1 = VDDIO in range
- force_off_i  in  1  synchronous request to hold the ring in the safe state
- cfg_debounce_i  in  DEBOUNCE_W  debounce length D (static while not OFF)
- cfg_step_i  in  STEP_W  step length T per release stage; 0 is treated as 1
- pad_iso_o  out  1  1 = pad inputs isolated / clamped
- pad_ret_o  out  1  1 = pad state retained
- pad_oe_en_o  out  1  1 = functional output enables allowed
- io_ready_o  out  1  ring fully up
- state_o  out  3  current state encoding, for debug
- drop_cnt_o  out  8  saturating count of supply drops

## Operation
- States: OFF(0), DEBOUNCE(1), ISO_REL(2), RET_REL(3), READY(4). All other encodings go to OFF.
- Outputs are Moore-decoded from the state register.
  - OFF / DEBOUNCE: iso=1, ret=1, oe_en=0, ready=0.
  - ISO_REL: iso=0, ret=1.
  - RET_REL: iso=0, ret=0.
  - READY: iso=0, ret=0, oe_en=1, ready=1.
- `ok_s` is the synchronised vsup_ok_ai. `loss` = !ok_s || force_off_i.
- OFF → DEBOUNCE when !loss. The counter is cleared on entry.
- DEBOUNCE:
  - Counter increments every cycle.
  - loss → OFF. This does not count as a drop.
  - When cnt == D → ISO_REL, and the counter clears.
- ISO_REL: after max(T,1) cycles → RET_REL, and the counter clears.
- RET_REL: after max(T,1) cycles → READY.
- READY: hold state.
- loss in ISO_REL, RET_REL or READY → OFF.
  - drop_cnt increments only when !ok_s caused the loss.
  - force_off alone does not increment it.
  - drop_cnt saturates at 255.
- If loss and a timer expiry occur in the same cycle, loss wins.
- Reset values:
  - state=OFF, so pad_iso_o=1, pad_ret_o=1, pad_oe_en_o=0, io_ready_o=0.
  - drop_cnt_o=0, counter=0.
  - Synchroniser flops reset to 0.
- Reset asserted mid-sequence forces all outputs to their reset values immediately and asynchronously. drop_cnt_o is cleared.

## Timing
- The async rise of vsup_ok_ai is seen as ok_s after S = SYNC_STAGES edges.
- Power-up latency: rise sampled before edge 0 → io_ready_o high after edge S+2+D+2·max(T,1).
  - pad_iso_o falls after edge S+2+D.
  - pad_ret_o falls after edge S+2+D+max(T,1).
- Supply-loss latency: async fall → safe outputs after edge S+1.
- force_off_i → safe outputs after the next edge.
- Every output changes in the same cycle as the state register, with no glitches between state changes.
- cfg_* are sampled continuously. Changing them outside OFF gives undefined step lengths, but states remain legal.

## Structure
- Package io_seq_pkg holds:
  - the `io_seq_state_e` enum (3-bit, values as above)
  - safe-state output constants
  - `DROP_CNT_MAX = 8'hFF`
- Sub-module io_sync_ff: a parameterised SYNC_STAGES flop chain with async active-low reset to 0, instantiated once for vsup_ok_ai.
- Top level contains the FSM, one shared DEBOUNCE_W/STEP_W-max counter, and the drop counter.

## Test plan
- Reset then vsup_ok_ai=1, S=2, D=4, T=3 → pad_iso_o falls after edge 8, pad_ret_o after edge 11, io_ready_o=1 after edge 14.
- Glitch: vsup_ok_ai high for 3 cycles with D=4 → returns to OFF, iso/ret stay 1, drop_cnt_o=0.
- In READY, drop vsup_ok_ai → after edge 3, outputs safe, state_o=0, drop_cnt_o=1. A re-rise repeats the full sequence.
- In RET_REL, pulse force_off_i for one cycle → OFF next cycle, drop_cnt_o unchanged. The sequence restarts from DEBOUNCE.
- cfg_step_i=0, D=0 → each release stage lasts 1 cycle; io_ready_o after edge S+4.
- 300 supply drops from READY → drop_cnt_o saturates at 255. Assert rst_ni mid-sequence → all outputs at reset values asynchronously.
